// File: rtl/subservient_uart_dbg_loader.sv
// subservient_uart_dbg_loader: UART command frames -> Wishbone debug cycles; SUBSERVIENT_DBG_LOADER_READ_EN enables 'R' reads
module subservient_uart_dbg_loader #(
  parameter int CLKS_PER_BIT = 139,
  parameter bit RESET_DEBUG  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx,
  output logic        o_debug_mode,
  output logic [31:0] o_wb_dbg_adr,
  output logic [31:0] o_wb_dbg_dat,
  output logic [3:0]  o_wb_dbg_sel,
  output logic        o_wb_dbg_we,
  output logic        o_wb_dbg_stb,
  input  logic [31:0] i_wb_dbg_rdt,
  input  logic        i_wb_dbg_ack,
  output logic [31:0] o_rd_data,
  output logic        o_rd_valid,
  output logic        o_frame_err,
  output logic        o_overrun
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_CMD, P_ADDR, P_DATA, P_WB} p_state_t;
  logic rx_meta, rx_sync;
  rx_state_t rx_state, rx_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0] bit_idx, bit_next;
  logic [7:0] shreg, sh_next;
  logic byte_stb, byte_err;
  p_state_t p_state, p_next;
  logic [1:0] bcnt;
  logic wr, is_w, is_r, cmd_hit;
  assign is_w = shreg == 8'h57;
`ifdef SUBSERVIENT_DBG_LOADER_READ_EN
  assign is_r = shreg == 8'h52;
`else
  assign is_r = 1'b0;
`endif
  assign cmd_hit = byte_stb && p_state == P_CMD;
  assign o_wb_dbg_sel = {4{o_wb_dbg_stb}};
  // two-flop synchronizer, idle-high
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) {rx_sync, rx_meta} <= 2'b11;
    else {rx_sync, rx_meta} <= {rx_meta, i_rx};
  // receiver state and sampling registers
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      rx_state <= RX_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
    end else begin
      rx_state <= rx_next;
      cnt <= cnt_next;
      bit_idx <= bit_next;
      shreg <= sh_next;
    end
  // receiver next state: half-bit start check, then mid-bit sampling
  always_comb begin
    rx_next = rx_state;
    cnt_next = cnt + CW'(1);
    bit_next = bit_idx;
    sh_next = shreg;
    byte_stb = 1'b0;
    byte_err = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        cnt_next = '0;
        bit_next = '0;
        rx_next = rx_sync ? RX_IDLE : RX_START;
      end
      RX_START:
        if (cnt == HALF) begin
          cnt_next = '0;
          rx_next = rx_sync ? RX_IDLE : RX_DATA;
        end
      RX_DATA:
        if (cnt == FULL) begin
          cnt_next = '0;
          sh_next = {rx_sync, shreg[7:1]};
          bit_next = bit_idx + 3'd1;
          rx_next = bit_idx == 3'd7 ? RX_STOP : RX_DATA;
        end
      default:
        if (cnt == FULL) begin
          rx_next = RX_IDLE;
          byte_stb = rx_sync;
          byte_err = !rx_sync;
        end
    endcase
  end
  // parser next state; a framing error restarts command decode unless a bus cycle is open
  always_comb begin
    p_next = p_state;
    case (p_state)
      P_CMD:  if (byte_stb && (is_w || is_r)) p_next = P_ADDR;
      P_ADDR: if (byte_stb && bcnt == 2'd3) p_next = wr ? P_DATA : P_WB;
      P_DATA: if (byte_stb && bcnt == 2'd3) p_next = P_WB;
      default: if (i_wb_dbg_ack) p_next = P_CMD;
    endcase
    if (byte_err && p_state != P_WB) p_next = P_CMD;
  end
  // parser registers, bus request and status pulses
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      p_state <= P_CMD;
      bcnt <= '0;
      wr <= 1'b0;
      o_debug_mode <= RESET_DEBUG;
      o_wb_dbg_adr <= '0;
      o_wb_dbg_dat <= '0;
      o_wb_dbg_we <= 1'b0;
      o_wb_dbg_stb <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      p_state <= p_next;
      bcnt <= p_next != p_state ? 2'd0 : bcnt + {1'b0, byte_stb};
      if (cmd_hit && (is_w || is_r)) wr <= is_w;
      if (cmd_hit && shreg == 8'h48) o_debug_mode <= 1'b1;
      else if (cmd_hit && shreg == 8'h47) o_debug_mode <= 1'b0;
      if (byte_stb && p_state == P_ADDR) o_wb_dbg_adr <= {shreg, o_wb_dbg_adr[31:8]};
      if (byte_stb && p_state == P_DATA) o_wb_dbg_dat <= {shreg, o_wb_dbg_dat[31:8]};
      o_wb_dbg_stb <= p_next == P_WB;
      o_wb_dbg_we <= p_next == P_WB && wr;
      o_frame_err <= byte_err;
      o_overrun <= byte_stb && p_state == P_WB;
    end
`ifdef SUBSERVIENT_DBG_LOADER_READ_EN
  // capture read data on the acknowledged read cycle
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_rd_data <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= o_wb_dbg_stb && i_wb_dbg_ack && !o_wb_dbg_we;
      if (o_wb_dbg_stb && i_wb_dbg_ack && !o_wb_dbg_we) o_rd_data <= i_wb_dbg_rdt;
    end
`else
  logic unused_rdt;
  assign unused_rdt = ^i_wb_dbg_rdt;
  assign o_rd_data = '0;
  assign o_rd_valid = 1'b0;
`endif
endmodule

// File: tb/tb_subservient_uart_dbg_loader.sv
// tb_subservient_uart_dbg_loader: directed self-checking bench for the UART debug loader
module tb_subservient_uart_dbg_loader;
  localparam int CPB = 16;
  logic clk = 1'b0, rst_n = 1'b1, rx = 1'b1, ack, ack_en = 1'b1;
  logic [31:0] rdt = '0;
  logic debug_mode, we, stb, rd_valid, frame_err, overrun;
  logic [31:0] adr, dat, rd_data;
  logic [3:0] sel;
  int total = 0, bad = 0, ack_dly = 0, stb_cyc = 0;
  logic stb_prev = 1'b0, cap_we = 1'b0;
  logic [31:0] cap_adr = '0, cap_dat = '0;
  logic [3:0] cap_sel = '0;
  int w = 0, last_w = 0, n_done = 0, unstable = 0, sel_idle_bad = 0, fe_cnt = 0, ov_cnt = 0, rv_cnt = 0;
  typedef struct {
    logic [7:0] cmd;
    logic [31:0] adr;
    logic [31:0] dat;
    int dly;
    logic exp_dbg;
  } vec_t;
  vec_t vecs[8];

  subservient_uart_dbg_loader #(.CLKS_PER_BIT(CPB), .RESET_DEBUG(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .o_debug_mode(debug_mode),
    .o_wb_dbg_adr(adr), .o_wb_dbg_dat(dat), .o_wb_dbg_sel(sel), .o_wb_dbg_we(we),
    .o_wb_dbg_stb(stb), .i_wb_dbg_rdt(rdt), .i_wb_dbg_ack(ack), .o_rd_data(rd_data),
    .o_rd_valid(rd_valid), .o_frame_err(frame_err), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) stb_cyc <= stb ? stb_cyc + 1 : 0;
  assign ack = ack_en && stb && (stb_cyc >= ack_dly);

  always @(negedge clk) begin
    if (stb) begin
      if (!stb_prev) begin
        cap_adr <= adr;
        cap_dat <= dat;
        cap_we <= we;
        cap_sel <= sel;
        w <= 1;
      end else begin
        w <= w + 1;
        if (adr !== cap_adr || dat !== cap_dat || we !== cap_we || sel !== cap_sel) unstable <= unstable + 1;
      end
    end else begin
      if (stb_prev) begin
        last_w <= w;
        n_done <= n_done + 1;
      end
      if (sel !== 4'h0) sel_idle_bad <= sel_idle_bad + 1;
    end
    stb_prev <= stb;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
    if (rd_valid) rv_cnt <= rv_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_w(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
  endtask

  task automatic wait_done(input int prev, input string nm);
    for (int k = 0; k < 400 && n_done == prev; k++) @(negedge clk);
    chk({nm, "_done"}, 32'(n_done == prev + 1), 32'd1);
  endtask

  task automatic wait_stb(input string nm);
    for (int k = 0; k < 400 && !stb; k++) @(negedge clk);
    chk({nm, "_stb_up"}, 32'(stb), 32'd1);
  endtask

  initial begin
    int prev, fe0, ov0, rv0;
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int prev, fe0, ov0, rv0;
    vecs[0] = '{8'h47, 32'h0, 32'h0, 0, 1'b0};
    vecs[1] = '{8'h48, 32'h0, 32'h0, 0, 1'b1};
    vecs[2] = '{8'h41, 32'h0, 32'h0, 0, 1'b1};
    vecs[3] = '{8'h57, 32'h0000_1000, 32'hDEAD_BEEF, 3, 1'b1};
    vecs[4] = '{8'h47, 32'h0, 32'h0, 0, 1'b0};
    vecs[5] = '{8'h57, 32'hFFFF_FFFC, 32'h0000_0001, 0, 1'b0};
    vecs[6] = '{8'h57, 32'h8000_0000, 32'hA5A5_5A5A, 1, 1'b0};
    vecs[7] = '{8'h48, 32'h0, 32'h0, 0, 1'b1};
    #1 rst_n = 1'b0;
    #3;
    chk("rst_debug", 32'(debug_mode), 32'd1);
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_dat", dat, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      prev = n_done;
      if (vecs[i].cmd == 8'h57) begin
        ack_dly = vecs[i].dly;
        send_w(vecs[i].adr, vecs[i].dat);
        wait_done(prev, $sformatf("v%0d", i));
        chk($sformatf("v%0d_adr", i), cap_adr, vecs[i].adr);
        chk($sformatf("v%0d_dat", i), cap_dat, vecs[i].dat);
        chk($sformatf("v%0d_we", i), 32'(cap_we), 32'd1);
        chk($sformatf("v%0d_sel", i), 32'(cap_sel), 32'hF);
        chk($sformatf("v%0d_width", i), 32'(last_w), 32'(vecs[i].dly + 1));
      end else begin
        send_byte(vecs[i].cmd, 1'b1);
        chk($sformatf("v%0d_no_stb", i), 32'(n_done), 32'(prev));
      end
      chk($sformatf("v%0d_debug", i), 32'(debug_mode), 32'(vecs[i].exp_dbg));
    end

    prev = n_done;
    fe0 = fe_cnt;
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h33, 1'b0);
    chk("ferr_pulse", 32'(fe_cnt), 32'(fe0 + 1));
    ack_dly = 2;
    send_w(32'h0000_0008, 32'hCAFE_F00D);
    wait_done(prev, "ferr_next");
    chk("ferr_next_adr", cap_adr, 32'h0000_0008);
    chk("ferr_next_dat", cap_dat, 32'hCAFE_F00D);
    chk("ferr_next_width", 32'(last_w), 32'd3);

    ack_en = 1'b0;
    prev = n_done;
    send_w(32'h0000_0100, 32'h1111_2222);
    wait_stb("ovr");
    ov0 = ov_cnt;
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_no_byte", 32'(ov_cnt), 32'(ov0));
    chk("glitch_no_ferr", 32'(fe_cnt), 32'(fe0));
    send_byte(8'hA5, 1'b1);
    chk("ovr_pulse", 32'(ov_cnt), 32'(ov0 + 1));
    chk("ovr_adr", adr, 32'h0000_0100);
    chk("ovr_dat", dat, 32'h1111_2222);
    chk("ovr_stb_held", 32'(stb), 32'd1);
    ack_en = 1'b1;
    wait_done(prev, "ovr");

`ifdef SUBSERVIENT_DBG_LOADER_READ_EN
    rdt = 32'h1234_5678;
    ack_dly = 0;
    prev = n_done;
    rv0 = rv_cnt;
    send_byte(8'h52, 1'b1);
    send_byte(8'h04, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
    wait_done(prev, "rd");
    chk("rd_adr", cap_adr, 32'h0000_0004);
    chk("rd_we", 32'(cap_we), 32'd0);
    chk("rd_width", 32'(last_w), 32'd1);
    chk("rd_valid_once", 32'(rv_cnt), 32'(rv0 + 1));
    chk("rd_data", rd_data, 32'h1234_5678);
`else
    rdt = 32'h1234_5678;
    prev = n_done;
    send_byte(8'h52, 1'b1);
    send_byte(8'h04, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    chk("r_ignored_no_stb", 32'(n_done), 32'(prev));
    chk("r_ignored_rv", 32'(rv_cnt), 32'd0);
    chk("r_ignored_rd_data", rd_data, 32'd0);
    ack_dly = 1;
    send_w(32'h0000_0040, 32'h0BAD_F00D);
    wait_done(prev, "after_r");
    chk("after_r_adr", cap_adr, 32'h0000_0040);
    chk("after_r_dat", cap_dat, 32'h0BAD_F00D);
    chk("after_r_we", 32'(cap_we), 32'd1);
`endif

    send_byte(8'h47, 1'b1);
    chk("pre_rst_debug", 32'(debug_mode), 32'd0);
    ack_en = 1'b0;
    send_w(32'h0000_0020, 32'h0000_0055);
    wait_stb("midrst");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_stb", 32'(stb), 32'd0);
    chk("midrst_sel", 32'(sel), 32'd0);
    chk("midrst_adr", adr, 32'd0);
    chk("midrst_debug", 32'(debug_mode), 32'd1);
    #3 rst_n = 1'b1;
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h47, 1'b1);
    chk("post_rst_cmd", 32'(debug_mode), 32'd0);

    chk("stb_stable", 32'(unstable), 32'd0);
    chk("sel_idle", 32'(sel_idle_bad), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
